// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w
// Brief    : Parametrised 2-read/1-write register file with registered read
//            ports, byte-strobed writes and a hardware clear sequencer that
//            zeroes the array one entry per cycle without a reset.
//            Optional build macro REGFILE_2R1W_BYPASS_EN turns same-cycle
//            read-during-write from read-first into write-first.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  localparam int STRB_W = WIDTH / 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic [STRB_W-1:0] WrStrb,
  input  logic              RdEnA,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [WIDTH-1:0]  RdDataA,
  output logic              RdValidA,
  input  logic              RdEnB,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [WIDTH-1:0]  RdDataB,
  output logic              RdValidB,
  input  logic              ClrReq,
  output logic              Busy,
  output logic              WrDrop
);

  // One extra bit so the range check also works when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;
  logic [WIDTH-1:0]  r_rd_data_a;
  logic              r_rd_valid_a;
  logic [WIDTH-1:0]  r_rd_data_b;
  logic              r_rd_valid_b;
  logic              r_wr_drop;

  logic              w_wr_in_range;
  logic              w_wr_accept;
  logic              w_wr_drop;
  logic [WIDTH-1:0]  w_wr_old;
  logic [WIDTH-1:0]  w_wr_merged;
  logic [WIDTH-1:0]  w_rd_a_raw;
  logic [WIDTH-1:0]  w_rd_b_raw;
  logic              w_byp_a;
  logic              w_byp_b;
  logic [WIDTH-1:0]  w_rd_a;
  logic [WIDTH-1:0]  w_rd_b;

  // Writes are only accepted in range and while no clear sweep owns the array.
  assign w_wr_in_range = ({1'b0, WrAddr} < c_depth);
  assign w_wr_accept   = WrEn & w_wr_in_range & ~r_busy;
  assign w_wr_drop     = WrEn & ~w_wr_accept;

  // Address decode for the write target and both read ports; addresses with
  // no matching entry fall through to zero.
  always_comb begin
    w_wr_old   = '0;
    w_rd_a_raw = '0;
    w_rd_b_raw = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (WrAddr == ADDR_W'(i)) begin
        w_wr_old = r_mem[i];
      end
      if (RdAddrA == ADDR_W'(i)) begin
        w_rd_a_raw = r_mem[i];
      end
      if (RdAddrB == ADDR_W'(i)) begin
        w_rd_b_raw = r_mem[i];
      end
    end
  end

  // Byte-lane merge: strobed lanes take new data, the rest keep old contents.
  for (genvar k = 0; k < STRB_W; k++) begin : g_byte
    assign w_wr_merged[8*k +: 8] = WrStrb[k] ? WrData[8*k +: 8] : w_wr_old[8*k +: 8];
  end

`ifdef REGFILE_2R1W_BYPASS_EN
  // Write-first: a read hitting the accepted write sees the merged word.
  assign w_byp_a = w_wr_accept & (RdAddrA == WrAddr);
  assign w_byp_b = w_wr_accept & (RdAddrB == WrAddr);
`else
  // Read-first: reads always see the array contents before this edge.
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  assign w_rd_a = w_byp_a ? w_wr_merged : w_rd_a_raw;
  assign w_rd_b = w_byp_b ? w_wr_merged : w_rd_b_raw;

  // Storage array: sweep clears one entry per cycle, otherwise accepted writes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((r_state == ST_SWEEP) && (r_ptr == ADDR_W'(i))) begin
          r_mem[i] <= '0;
        end else if (w_wr_accept && (WrAddr == ADDR_W'(i))) begin
          r_mem[i] <= w_wr_merged;
        end
      end
    end
  end

  // Clear sequencer: IDLE -> SWEEP for exactly DEPTH cycles -> IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ClrReq) begin
            r_state <= ST_SWEEP;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (r_ptr == c_last) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + ADDR_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ptr   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Port A read register: data holds when idle, valid is a one-cycle pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rd_data_a  <= '0;
      r_rd_valid_a <= 1'b0;
    end else begin
      r_rd_valid_a <= RdEnA;
      if (RdEnA) begin
        r_rd_data_a <= w_rd_a;
      end
    end
  end

  // Port B read register, independent of port A.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rd_data_b  <= '0;
      r_rd_valid_b <= 1'b0;
    end else begin
      r_rd_valid_b <= RdEnB;
      if (RdEnB) begin
        r_rd_data_b <= w_rd_b;
      end
    end
  end

  // Dropped-write flag, one cycle after the discarded request.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_wr_drop;
    end
  end

  assign RdDataA  = r_rd_data_a;
  assign RdValidA = r_rd_valid_a;
  assign RdDataB  = r_rd_data_b;
  assign RdValidB = r_rd_valid_b;
  assign Busy     = r_busy;
  assign WrDrop   = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_2r1w
// Brief    : Self-checking bench for regfile_2r1w. Drives a DEPTH=8 and a
//            DEPTH=6 instance with shared stimulus and compares both against
//            an array-based reference model every cycle, plus directed
//            literal checks. Honours REGFILE_2R1W_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w;

  localparam int NDUT = 2;
  localparam int MAXD = 8;
`ifdef REGFILE_2R1W_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK     = 1'b0;
  logic        RST     = 1'b0;
  logic        WrEn    = 1'b0;
  logic [2:0]  WrAddr  = '0;
  logic [15:0] WrData  = '0;
  logic [1:0]  WrStrb  = '0;
  logic        RdEnA   = 1'b0;
  logic [2:0]  RdAddrA = '0;
  logic        RdEnB   = 1'b0;
  logic [2:0]  RdAddrB = '0;
  logic        ClrReq  = 1'b0;

  logic [15:0] rda   [NDUT];
  logic        va    [NDUT];
  logic [15:0] rdb   [NDUT];
  logic        vb    [NDUT];
  logic        busy  [NDUT];
  logic        wdrop [NDUT];

  // Reference model state and expected outputs
  logic [15:0] m_mem   [NDUT][MAXD];
  int          m_sweep [NDUT];
  logic [15:0] e_rda   [NDUT];
  logic        e_va    [NDUT];
  logic [15:0] e_rdb   [NDUT];
  logic        e_vb    [NDUT];
  logic        e_busy  [NDUT];
  logic        e_wd    [NDUT];

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;
  int busy_n;

  regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) u_dut8 (
    .CLK(CLK), .RST(RST),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrStrb(WrStrb),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(rda[0]), .RdValidA(va[0]),
    .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(rdb[0]), .RdValidB(vb[0]),
    .ClrReq(ClrReq), .Busy(busy[0]), .WrDrop(wdrop[0])
  );

  regfile_2r1w #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) u_dut6 (
    .CLK(CLK), .RST(RST),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrStrb(WrStrb),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(rda[1]), .RdValidA(va[1]),
    .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(rdb[1]), .RdValidB(vb[1]),
    .ClrReq(ClrReq), .Busy(busy[1]), .WrDrop(wdrop[1])
  );

  always #5 CLK = ~CLK;

  function automatic int dep(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] s);
    logic [15:0] r;
    r = old;
    if (s[0]) r[7:0]  = nw[7:0];
    if (s[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  function automatic logic [15:0] rd_exp(input int k, input logic [2:0] a, input logic acc, input logic [15:0] mrg);
    if (int'(a) >= dep(k)) return 16'h0;
    if (BYP && acc && (a == WrAddr)) return mrg;
    return m_mem[k][a];
  endfunction

  // Reference model: evaluates the register-file rules at every rising edge.
  always @(posedge CLK or negedge RST) begin : model
    int          d;
    logic        bz;
    logic        acc;
    logic [15:0] mrg;
    for (int k = 0; k < NDUT; k++) begin
      if (!RST) begin
        for (int i = 0; i < MAXD; i++) m_mem[k][i] = 16'h0;
        m_sweep[k] = -1;
        e_rda[k] = 16'h0; e_va[k] = 1'b0;
        e_rdb[k] = 16'h0; e_vb[k] = 1'b0;
        e_busy[k] = 1'b0; e_wd[k] = 1'b0;
      end else begin
        d   = dep(k);
        bz  = (m_sweep[k] >= 0);
        acc = WrEn && (int'(WrAddr) < d) && !bz;
        e_wd[k] = WrEn && !acc;
        mrg = merge(m_mem[k][WrAddr], WrData, WrStrb);
        e_va[k] = RdEnA;
        if (RdEnA) e_rda[k] = rd_exp(k, RdAddrA, acc, mrg);
        e_vb[k] = RdEnB;
        if (RdEnB) e_rdb[k] = rd_exp(k, RdAddrB, acc, mrg);
        if (acc) m_mem[k][WrAddr] = mrg;
        if (bz) begin
          m_mem[k][m_sweep[k]] = 16'h0;
          m_sweep[k] = m_sweep[k] + 1;
          if (m_sweep[k] == d) m_sweep[k] = -1;
        end else if (ClrReq) begin
          m_sweep[k] = 0;
        end
        e_busy[k] = (m_sweep[k] >= 0);
      end
    end
  end

  // Compare process: every output of both instances, mid-cycle.
  always @(negedge CLK) begin
    if (cmp_on) begin
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("d%0d_RdDataA", k),  rda[k],   e_rda[k]);
        check($sformatf("d%0d_RdValidA", k), va[k],    e_va[k]);
        check($sformatf("d%0d_RdDataB", k),  rdb[k],   e_rdb[k]);
        check($sformatf("d%0d_RdValidB", k), vb[k],    e_vb[k]);
        check($sformatf("d%0d_Busy", k),     busy[k],  e_busy[k]);
        check($sformatf("d%0d_WrDrop", k),   wdrop[k], e_wd[k]);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WrEn = 1'b0; RdEnA = 1'b0; RdEnB = 1'b0; ClrReq = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] dat, input logic [1:0] s);
    WrEn = 1'b1; WrAddr = a; WrData = dat; WrStrb = s;
    tick();
    WrEn = 1'b0;
  endtask

  initial begin
    // Reset
    tick(); tick();
    cmp_on = 1'b1;
    check("rst_busy", busy[0], 16'h0);
    check("rst_rda", rda[0], 16'h0);
    check("rst_va", va[0], 16'h0);
    check("rst_wdrop", wdrop[0], 16'h0);
    RST = 1'b1;
    tick();

    // Reads straight after reset
    RdEnA = 1'b1; RdAddrA = 3'd3; RdEnB = 1'b1; RdAddrB = 3'd7;
    tick();
    check("post_rst_rda", rda[0], 16'h0);
    check("post_rst_va", va[0], 16'h1);
    check("post_rst_rdb", rdb[0], 16'h0);
    check("post_rst_vb", vb[0], 16'h1);
    idle_inputs();
    tick();
    check("va_pulse", va[0], 16'h0);
    check("vb_pulse", vb[0], 16'h0);

    // Byte strobes
    wr(3'd2, 16'hBEEF, 2'b11);
    wr(3'd2, 16'h12AA, 2'b01);
    RdEnA = 1'b1; RdAddrA = 3'd2;
    tick();
    check("strobe_merge", rda[0], 16'hBEAA);
    idle_inputs();

    // Read-during-write
    wr(3'd4, 16'h1111, 2'b11);
    WrEn = 1'b1; WrAddr = 3'd4; WrData = 16'h5555; WrStrb = 2'b11;
    RdEnA = 1'b1; RdAddrA = 3'd4;
    tick();
    check("rdw_same_cycle", rda[0], BYP ? 16'h5555 : 16'h1111);
    WrEn = 1'b0;
    tick();
    check("rdw_next_read", rda[0], 16'h5555);
    idle_inputs();

    // Fill, then clear sweep
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1001 + 16'(i) * 16'h0111, 2'b11);
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0;
    check("sweep_busy_start", busy[0], 16'h1);
    busy_n = busy[0] ? 1 : 0;
    WrEn = 1'b1; WrAddr = 3'd1; WrData = 16'hFFFF; WrStrb = 2'b11;
    tick();
    check("sweep_wrdrop", wdrop[0], 16'h1);
    if (busy[0]) busy_n++;
    WrEn = 1'b0; RdEnA = 1'b1; RdAddrA = 3'd7;
    tick();
    check("sweep_old_val", rda[0], 16'h1778);
    if (busy[0]) busy_n++;
    RdEnA = 1'b0;
    for (int i = 0; i < 20 && busy[0]; i++) begin
      tick();
      if (busy[0]) busy_n++;
    end
    check("sweep_len", 16'(busy_n), 16'd8);
    for (int i = 0; i < 8; i++) begin
      RdEnA = 1'b1; RdAddrA = 3'(i); RdEnB = 1'b1; RdAddrB = 3'(7 - i);
      tick();
      check($sformatf("cleared_a%0d", i), rda[0], 16'h0);
      check($sformatf("cleared_b%0d", 7 - i), rdb[0], 16'h0);
    end
    idle_inputs();

    // Out-of-range accesses on the DEPTH=6 instance
    wr(3'd6, 16'h6666, 2'b11);
    check("d6_drop_addr6", wdrop[1], 16'h1);
    wr(3'd7, 16'hABCD, 2'b11);
    check("d6_drop_addr7", wdrop[1], 16'h1);
    check("d8_no_drop", wdrop[0], 16'h0);
    RdEnA = 1'b1; RdAddrA = 3'd6; RdEnB = 1'b1; RdAddrB = 3'd7;
    tick();
    check("d6_oor_rda", rda[1], 16'h0);
    check("d6_oor_va", va[1], 16'h1);
    check("d6_oor_rdb", rdb[1], 16'h0);
    check("d8_rda6", rda[0], 16'h6666);
    check("d8_rdb7", rdb[0], 16'hABCD);
    idle_inputs();

    // Reset in the middle of a sweep
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hA000 + 16'(i), 2'b11);
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0; RdEnA = 1'b1; RdAddrA = 3'd5;
    tick();
    check("sweep2_old_val", rda[0], 16'hA005);
    RdEnA = 1'b0;
    tick();
    RST = 1'b0;
    #1;
    check("midrst_busy", busy[0], 16'h0);
    check("midrst_rda", rda[0], 16'h0);
    check("midrst_va", va[0], 16'h0);
    check("midrst_wdrop", wdrop[0], 16'h0);
    tick(); tick();
    RST = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      RdEnA = 1'b1; RdAddrA = 3'(i);
      tick();
      check($sformatf("rst_zero%0d", i), rda[0], 16'h0);
    end
    idle_inputs();
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0;
    check("clr_after_rst", busy[0], 16'h1);
    for (int i = 0; i < 20 && busy[0]; i++) tick();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      WrEn    = 1'($urandom_range(0, 1));
      WrAddr  = 3'($urandom_range(0, 7));
      WrData  = 16'($urandom);
      WrStrb  = 2'($urandom_range(0, 3));
      RdEnA   = 1'($urandom_range(0, 1));
      RdAddrA = ($urandom_range(0, 3) == 0) ? WrAddr : 3'($urandom_range(0, 7));
      RdEnB   = 1'($urandom_range(0, 1));
      RdAddrB = ($urandom_range(0, 3) == 0) ? WrAddr : 3'($urandom_range(0, 7));
      ClrReq  = ($urandom_range(0, 39) == 0);
      RST     = ($urandom_range(0, 299) != 0);
      tick();
    end
    idle_inputs();
    RST = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
